mdu_iter: RTL

- Parametrised iterative multiply/divide unit for the multi-cycle MIPS datapath.
- Executes mult, multu, div and divu over many cycles and holds results in HI/LO registers.
- The controller launches an operation with a start pulse, stalls on busy, and reads HI/LO (mfhi/mflo) after done.
- It also accepts direct HI/LO writes (mthi/mtlo).

---
 rtl/mdu_iter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO result registers.
//
// Purpose:
//   A start pulse launches mult, multu, div or divu. The unit spends W cycles
//   iterating and one cycle on sign correction. It then writes HI/LO and pulses
//   done. HI/LO can also be written directly (mthi/mtlo) while the unit is idle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   start  launch request; honoured only while idle
//   op     00 mult, 01 multu, 10 div, 11 divu
//   a, b   operands (rs, rt); sampled only on the start edge
//   hi_we  mthi write enable (idle only)
//   lo_we  mtlo write enable (idle only)
//   wdata  data for mthi/mtlo
//   busy   operation in progress
//   done   one-cycle pulse; HI/LO hold the new result from this cycle
//   dz     divide-by-zero flag of the last completed operation
//   hi,lo  HI and LO registers
module mdu_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]  cnt_reg;
  logic           is_div_reg;   // latched op[1]
  logic           neg_q_reg;    // product / quotient must be negated
  logic           neg_r_reg;    // remainder takes the dividend's sign
  logic           bzero_reg;    // divisor was zero
  logic [W-1:0]   opnd_reg;     // multiplicand (mult) or divisor (div)
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*W-1:0] acc_reg;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] acc_step, prod_fix;
  logic [W-1:0]   quot, rem, res_hi, res_lo;

  assign busy = (state_reg != IDLE);

  // Operand magnitudes; unsigned ops never negate.
  always_comb begin
    a_neg = ~op[0] & a[W-1];
    b_neg = ~op[0] & b[W-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (!is_div_reg) begin
      acc_step = {mul_sum, acc_reg[W-1:1]};
    end else if (!div_diff[W]) begin
      acc_step = {div_diff[W-1:0], acc_reg[W-2:0], 1'b1};
    end else begin
      acc_step = {div_shift[W-1:0], acc_reg[W-2:0], 1'b0};
    end
  end

  // Sign correction. With a zero divisor every trial subtract succeeds. The
  // remainder therefore ends as |a|, and restoring its sign gives back the raw
  // dividend for HI. LO is forced to all ones.
  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quot     = acc_reg[W-1:0];
    rem      = acc_reg[2*W-1:W];
    if (is_div_reg) begin
      res_hi = neg_r_reg ? -rem : rem;
      res_lo = bzero_reg ? '1 : (neg_q_reg ? -quot : quot);
    end else begin
      res_hi = prod_fix[2*W-1:W];
      res_lo = prod_fix[W-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == CW'(W-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      bzero_reg  <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      done       <= 1'b0;
      dz         <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div_reg <= op[1];
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            bzero_reg  <= (b == '0);
            opnd_reg   <= op[1] ? b_mag : a_mag;
            acc_reg    <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
          dz   <= is_div_reg & bzero_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
